// File: rtl/instruction_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instruction_memory_responder_pkg
// Brief   : Shared FSM encoding and constants for the instruction responder.
// Revision: 1.0 - initial release
// ============================================================================
package instruction_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [31:0] c_NOP            = 32'h0000_0013;
    localparam int          IMEM_MAX_LATENCY = 15;

endpackage
`default_nettype wire

// File: rtl/instruction_memory_responder_imem_array.sv
`default_nettype none
// ============================================================================
// Module  : imem_array
// Brief   : DEPTH x I_WIDTH word storage, one synchronous write port and one
//           registered read port (read register clears on reset, storage not).
// Revision: 1.0 - initial release
// ============================================================================
module imem_array #(
    parameter int I_WIDTH = 32,
    parameter int DEPTH   = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [I_WIDTH-1:0]       wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [I_WIDTH-1:0]       rdata_o
);

    logic [I_WIDTH-1:0] mem_q [DEPTH];
    logic [I_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-edge write to the word being read yields the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/instruction_memory_responder.sv
`default_nettype none
// ============================================================================
// Module  : instruction_memory_responder
// Brief   : Fixed-latency instruction fetch responder with flush and preload.
//           Optional macro IMEM_MISALIGN_ERR_EN adds o_err for misaligned fetches.
// Revision: 1.0 - initial release
// ============================================================================
module instruction_memory_responder
    import instruction_memory_responder_pkg::*;
#(
    parameter int I_WIDTH = 32,
    parameter int A_WIDTH = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic               im_clk,
    input  logic               im_rst_n,
    input  logic               i_syn,
    input  logic [A_WIDTH-1:0] i_addr_instr,
    input  logic               i_flush,
    output logic [I_WIDTH-1:0] o_instr,
    output logic               o_ack,
    input  logic               i_we,
    input  logic [A_WIDTH-1:0] i_waddr,
    input  logic [I_WIDTH-1:0] i_wdata,
    output logic               o_busy
`ifdef IMEM_MISALIGN_ERR_EN
    ,
    output logic               o_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(IMEM_MAX_LATENCY + 1);
    localparam logic [CNT_W-1:0] c_LOAD_FROM_ACK  = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] c_LOAD_FROM_IDLE = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic               nop_q;

    logic               w_take;
    logic               w_from_ack;
    logic               w_rd_en;
    logic               w_direct;
    logic [A_WIDTH-1:0] w_rd_addr;
    logic               w_rd_hi;
    logic               w_wr_hi;
    logic               w_misalign;
    logic [I_WIDTH-1:0] w_rdata;

    // A request accepted out of IDLE acks in the LATENCY-th cycle; one taken
    // back-to-back from ACK pays an extra turnaround cycle in WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        w_take     = 1'b0;
        w_from_ack = 1'b0;
        w_rd_en    = 1'b0;
        w_direct   = 1'b0;
        case (state_q)
            IDLE: begin
                w_take = i_syn;
            end
            ACK: begin
                state_d    = IDLE;
                w_take     = i_syn;
                w_from_ack = 1'b1;
            end
            WAIT: begin
                if (i_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    w_take  = i_syn;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                    w_rd_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (w_take) begin
            addr_d = i_addr_instr;
            if ((LATENCY == 1) && !w_from_ack) begin
                state_d  = ACK;
                cnt_d    = '0;
                w_rd_en  = 1'b1;
                w_direct = 1'b1;
            end else begin
                state_d = WAIT;
                cnt_d   = w_from_ack ? c_LOAD_FROM_ACK : c_LOAD_FROM_IDLE;
            end
        end
    end

    assign w_rd_addr = w_direct ? i_addr_instr : addr_q;

    generate
        if (A_WIDTH > IDX_W + 2) begin : g_range_chk
            assign w_rd_hi = |w_rd_addr[A_WIDTH-1:IDX_W+2];
            assign w_wr_hi = |i_waddr[A_WIDTH-1:IDX_W+2];
        end else begin : g_no_range_chk
            assign w_rd_hi = 1'b0;
            assign w_wr_hi = 1'b0;
        end
    endgenerate

`ifdef IMEM_MISALIGN_ERR_EN
    logic err_q;

    assign w_misalign = |w_rd_addr[1:0];

    always_ff @(posedge im_clk or negedge im_rst_n) begin
        if (!im_rst_n) begin
            err_q <= 1'b0;
        end else if (w_rd_en) begin
            err_q <= w_misalign;
        end
    end

    assign o_err = o_ack & err_q;
`else
    assign w_misalign = 1'b0;
`endif

    wire w_unused_bits = ^{i_waddr[1:0], w_rd_addr[1:0]};

    always_ff @(posedge im_clk or negedge im_rst_n) begin
        if (!im_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            nop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (w_rd_en) begin
                nop_q <= w_rd_hi | w_misalign;
            end
        end
    end

    imem_array #(
        .I_WIDTH (I_WIDTH),
        .DEPTH   (DEPTH)
    ) u_imem_array (
        .clk     (im_clk),
        .rst_n   (im_rst_n),
        .we_i    (i_we & ~w_wr_hi),
        .waddr_i (i_waddr[IDX_W+1:2]),
        .wdata_i (i_wdata),
        .re_i    (w_rd_en),
        .raddr_i (w_rd_addr[IDX_W+1:2]),
        .rdata_o (w_rdata)
    );

    assign o_instr = nop_q ? I_WIDTH'(c_NOP) : w_rdata;
    assign o_ack   = (state_q == ACK);
    assign o_busy  = (state_q == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_memory_responder
// Brief   : Two responders (LATENCY 1 and 3) on shared stimulus, checked each
//           cycle against a cycle-count model plus literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instruction_memory_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syn = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;
    logic        we = 1'b0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;

    logic [1:0]  dack;
    logic [1:0]  dbusy;
    logic [31:0] dinstr [2];
`ifdef IMEM_MISALIGN_ERR_EN
    logic [1:0]  derr;
    logic        merr [2];
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instruction_memory_responder #(.LATENCY(1)) u_dut1 (
        .im_clk(clk), .im_rst_n(rst_n), .i_syn(syn), .i_addr_instr(addr),
        .i_flush(flush), .o_instr(dinstr[0]), .o_ack(dack[0]), .i_we(we),
        .i_waddr(waddr), .i_wdata(wdata), .o_busy(dbusy[0])
`ifdef IMEM_MISALIGN_ERR_EN
        , .o_err(derr[0])
`endif
    );

    instruction_memory_responder #(.LATENCY(3)) u_dut3 (
        .im_clk(clk), .im_rst_n(rst_n), .i_syn(syn), .i_addr_instr(addr),
        .i_flush(flush), .o_instr(dinstr[1]), .o_ack(dack[1]), .i_we(we),
        .i_waddr(waddr), .i_wdata(wdata), .o_busy(dbusy[1])
`ifdef IMEM_MISALIGN_ERR_EN
        , .o_err(derr[1])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each outstanding request carries the cycle number in which its ack is due.
    int          lat [2] = '{1, 3};
    int          cyc = 0;
    logic        pend [2] = '{1'b0, 1'b0};
    logic        acking [2] = '{1'b0, 1'b0};
    int          ackcyc [2] = '{0, 0};
    logic [31:0] maddr [2] = '{32'h0, 32'h0};
    logic [31:0] mins [2] = '{32'h0, 32'h0};
    logic [31:0] mmem [0:1023];

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (a[31:12] != 20'h0) return NOP;
`ifdef IMEM_MISALIGN_ERR_EN
        if (a[1:0] != 2'b00) return NOP;
`endif
        return mmem[a[11:2]];
    endfunction

    always @(negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            pend[i]   = 1'b0;
            acking[i] = 1'b0;
            mins[i]   = '0;
`ifdef IMEM_MISALIGN_ERR_EN
            merr[i]   = 1'b0;
`endif
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                logic was_ack;
                logic take;
                was_ack   = acking[i];
                acking[i] = 1'b0;
                take      = 1'b0;
                if (pend[i]) begin
                    if (flush) begin
                        pend[i] = 1'b0;
                        take    = syn;
                        was_ack = 1'b0;
                    end
                end else begin
                    take = syn;
                end
                if (take) begin
                    pend[i]   = 1'b1;
                    maddr[i]  = addr;
                    ackcyc[i] = cyc + lat[i] - 1 + (was_ack ? 1 : 0);
                end
                if (pend[i] && ackcyc[i] == cyc) begin
                    mins[i]   = exp_word(maddr[i]);
`ifdef IMEM_MISALIGN_ERR_EN
                    merr[i]   = (maddr[i][1:0] != 2'b00);
`endif
                    acking[i] = 1'b1;
                    pend[i]   = 1'b0;
                end
            end
            if (we && waddr[31:12] == 20'h0) mmem[waddr[11:2]] = wdata;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_ack[%0d]", i), {31'h0, dack[i]}, {31'h0, acking[i]});
            chk($sformatf("model_busy[%0d]", i), {31'h0, dbusy[i]}, {31'h0, pend[i]});
            if (!$isunknown(mins[i]))
                chk($sformatf("model_instr[%0d]", i), dinstr[i], mins[i]);
`ifdef IMEM_MISALIGN_ERR_EN
            chk($sformatf("model_err[%0d]", i), {31'h0, derr[i]}, {31'h0, acking[i] & merr[i]});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        waddr = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic req(input logic [31:0] a);
        syn = 1'b1; addr = a;
        step();
        syn = 1'b0;
    endtask

    initial begin
        int n1;
        int n3;
        #2;
        chk("rst_ack", {30'h0, dack}, 32'h0);
        chk("rst_busy", {30'h0, dbusy}, 32'h0);
        chk("rst_instr1", dinstr[0], 32'h0);
        chk("rst_instr3", dinstr[1], 32'h0);
        idle(2);
        rst_n = 1'b1;

        wr(32'h0000_0000, 32'hA0A0_A0A0);
        wr(32'h0000_0004, 32'hB1B1_B1B1);
        wr(32'h0000_0008, 32'hC2C2_C2C2);
        wr(32'h0000_0100, 32'hD3D3_D3D3);
        wr(32'h0000_0FFC, 32'hE4E4_E4E4);
        wr(32'h0000_1000, 32'h9999_9999);
        idle(2);

        // LATENCY=1: ack in the cycle right after the accept edge
        req(32'h0);
        chk("l1_ack", {31'h0, dack[0]}, 32'h1);
        chk("l1_instr", dinstr[0], 32'hA0A0_A0A0);
        idle(5);

        // LATENCY=3: busy two cycles, ack in the third
        req(32'h4);
        chk("l3_busy_c1", {31'h0, dbusy[1]}, 32'h1);
        chk("l3_noack_c1", {31'h0, dack[1]}, 32'h0);
        step();
        chk("l3_busy_c2", {31'h0, dbusy[1]}, 32'h1);
        step();
        chk("l3_ack_c3", {31'h0, dack[1]}, 32'h1);
        chk("l3_busy_c3", {31'h0, dbusy[1]}, 32'h0);
        chk("l3_instr", dinstr[1], 32'hB1B1_B1B1);
        idle(5);

        // flush with a new request on the same cycle
        req(32'h8);
        flush = 1'b1; syn = 1'b1; addr = 32'h100;
        step();
        flush = 1'b0; syn = 1'b0;
        chk("flush_noack_a", {31'h0, dack[1]}, 32'h0);
        step();
        chk("flush_noack_b", {31'h0, dack[1]}, 32'h0);
        step();
        chk("flush_new_ack", {31'h0, dack[1]}, 32'h1);
        chk("flush_new_instr", dinstr[1], 32'hD3D3_D3D3);
        idle(5);

        // flush alone in IDLE does nothing
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle(3);

        // out of range fetch and array boundaries
        req(32'h0001_0000);
        chk("oor_ack", {31'h0, dack[0]}, 32'h1);
        chk("oor_instr", dinstr[0], NOP);
        idle(5);
        req(32'h0000_0FFC);
        idle(5);
        req(32'h0000_1000);
        idle(5);
        req(32'h0);
        chk("oor_write_ignored", dinstr[0], 32'hA0A0_A0A0);
        idle(5);

        // continuous request stream
        n1 = 0; n3 = 0;
        syn = 1'b1; addr = 32'h4;
        for (int k = 0; k < 8; k++) begin
            step();
            n1 += int'(dack[0]);
            n3 += int'(dack[1]);
        end
        syn = 1'b0;
        chk("stream_acks_l1", n1, 32'd4);
        chk("stream_acks_l3", n3, 32'd2);
        idle(6);

        // same-edge write to the word being read returns old data
        syn = 1'b1; addr = 32'h8; we = 1'b1; waddr = 32'h8; wdata = 32'hF5F5_F5F5;
        step();
        syn = 1'b0; we = 1'b0;
        chk("wcol_ack", {31'h0, dack[0]}, 32'h1);
        chk("wcol_old", dinstr[0], 32'hC2C2_C2C2);
        idle(2);
        chk("wcol_l3_new", dinstr[1], 32'hF5F5_F5F5);
        idle(5);

        // asynchronous reset mid-WAIT
        req(32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ack", {30'h0, dack}, 32'h0);
        chk("arst_busy", {30'h0, dbusy}, 32'h0);
        chk("arst_instr1", dinstr[0], 32'h0);
        chk("arst_instr3", dinstr[1], 32'h0);
        step();
        rst_n = 1'b1;
        idle(6);
        req(32'h0);
        chk("post_rst_instr", dinstr[0], 32'hA0A0_A0A0);
        idle(5);

`ifdef IMEM_MISALIGN_ERR_EN
        req(32'h2);
        chk("mis_err", {31'h0, derr[0]}, 32'h1);
        chk("mis_ack", {31'h0, dack[0]}, 32'h1);
        chk("mis_instr", dinstr[0], NOP);
        idle(5);
        req(32'h0);
        chk("align_err", {31'h0, derr[0]}, 32'h0);
        chk("align_instr", dinstr[0], 32'hA0A0_A0A0);
        idle(5);
`else
        req(32'h2);
        chk("lowbits_ignored", dinstr[0], 32'hA0A0_A0A0);
        idle(5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
